fir_mac_sched: RTL and testbench

- Time-multiplexed FIR engine for the accelerometer filter path.
- Shares one multiply-accumulate (MAC) unit between N_CH sample requesters (X/Y/Z axes) using round-robin arbitration.
- Holds one tap delay line per channel and a coefficient table that is writable at runtime.
- Sits between the axis sample sources and downstream consumers; replaces per-axis parallel-multiplier FIR instances.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_mac_sched_rr_arbiter.sv | 29 ++
 rtl/fir_mac_sched.sv | 142 ++++++++++++++
 tb/tb_fir_mac_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR engine.
package fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_MAC,
    S_DONE
  } fir_state_e;

  localparam int N_CH_DEF  = 3;
  localparam int TAPS_DEF  = 4;
  localparam int DW_DEF    = 16;
  localparam int CW_DEF    = 16;
  localparam int SHIFT_DEF = 0;

  // Tap 0 resets to unity so the filter starts as a passthrough.
  localparam int COEF_TAP0_RST = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_w(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac_sched_rr_arbiter.sv
// Round-robin arbiter: lowest-indexed request at or after ptr wins.
module rr_arbiter #(
  parameter int N_CH = 3,
  parameter int CHW  = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CHW-1:0]  ptr,
  output logic [N_CH-1:0] grant,
  output logic [CHW-1:0]  grant_idx
);

  int idx;

  // Scan farthest offset first so the nearest request overwrites.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_CH;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = CHW'(idx);
      end
    end
  end

endmodule

// File: rtl/fir_mac_sched.sv
// Shared-MAC FIR engine for N_CH sample channels, round-robin scheduled.
// Define FIR_SAT_EN to saturate the output instead of wrapping it.
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int TAPS  = TAPS_DEF,
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req_valid,
  output logic [N_CH-1:0]          req_ready,
  input  logic [N_CH*DW-1:0]       req_data,
  input  logic                     coef_we,
  output logic                     coef_ready,
  input  logic [idx_w(TAPS)-1:0]   coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     out_valid,
  output logic [idx_w(N_CH)-1:0]   out_ch,
  output logic [DW-1:0]            out_data,
  output logic                     busy
);

  localparam int CHW   = idx_w(N_CH);
  localparam int KW    = idx_w(TAPS);
  localparam int PW    = DW + CW;
  localparam int ACC_W = acc_w(DW, CW, TAPS);

  fir_state_e state, next;

  logic [CHW-1:0]          rr_ptr;
  logic [CHW-1:0]          gnt_idx;
  logic [CHW-1:0]          ch_q;
  logic [N_CH-1:0]         gnt;
  logic                    xfer;
  logic signed [DW-1:0]    sample_q;
  logic signed [DW-1:0]    line [N_CH][TAPS];
  logic signed [CW-1:0]    coef [TAPS];
  logic [KW-1:0]           k;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic signed [PW-1:0]    prod;
  logic [DW-1:0]           res;

  rr_arbiter #(
    .N_CH (N_CH),
    .CHW  (CHW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  assign req_ready  = (state == S_IDLE && rst_n) ? gnt : '0;
  assign xfer       = |(req_valid & req_ready);
  assign coef_ready = (state == S_IDLE) && !xfer;
  assign busy       = (state != S_IDLE);

  assign prod    = PW'(line[ch_q][k]) * PW'(coef[k]);
  assign shifted = acc >>> SHIFT;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;

  always_comb begin
    res = DW'(shifted);
    if (shifted > MAXV) res = MAXV[DW-1:0];
    else if (shifted < MINV) res = MINV[DW-1:0];
  end
`else
  always_comb begin
    res = DW'(shifted);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:  if (xfer) next = S_SHIFT;
      S_SHIFT: next = S_MAC;
      S_MAC:   if (k == KW'(TAPS - 1)) next = S_DONE;
      S_DONE:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++)
        for (int t = 0; t < TAPS; t++)
          line[c][t] <= '0;
      for (int t = 0; t < TAPS; t++)
        coef[t] <= (t == 0) ? CW'(COEF_TAP0_RST) : '0;
      rr_ptr    <= '0;
      ch_q      <= '0;
      sample_q  <= '0;
      k         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (coef_we && coef_ready) coef[coef_addr] <= coef_data;
      if (xfer) begin
        ch_q     <= gnt_idx;
        sample_q <= req_data[gnt_idx*DW +: DW];
        rr_ptr   <= (gnt_idx == CHW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
      case (state)
        S_SHIFT: begin
          for (int t = TAPS - 1; t > 0; t--)
            line[ch_q][t] <= line[ch_q][t-1];
          line[ch_q][0] <= sample_q;
          acc <= '0;
          k   <= '0;
        end
        S_MAC: begin
          acc <= acc + ACC_W'(prod);
          k   <= k + 1'b1;
        end
        S_DONE: begin
          out_valid <= 1'b1;
          out_ch    <= ch_q;
          out_data  <= res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed self-checking bench for fir_mac_sched (defaults: 3 ch, 4 taps).
module tb_fir_mac_sched;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [47:0] req_data;
  logic        coef_we;
  logic        coef_ready;
  logic [1:0]  coef_addr;
  logic [15:0] coef_data;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [15:0] out_data;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  fir_mac_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .coef_we    (coef_we),
    .coef_ready (coef_ready),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [15:0] d);
    int n;
    n = 0;
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    #1;
    while (!coef_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("coef_accept", coef_ready, 1);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic accept(input int ch, input logic [15:0] d);
    int n;
    n = 0;
    req_data[ch*16 +: 16] = d;
    req_valid[ch] = 1'b1;
    #1;
    while (!req_ready[ch] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("grant", req_ready[ch], 1);
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
  endtask

  task automatic wait_result(input int ch, input logic [15:0] d);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, 6);
    check("out_ch", out_ch, ch);
    check("out_data", out_data, d);
  endtask

  initial begin
    int res, cyc, idle_run, nvalid;
    logic [15:0] imp [5];
    logic [15:0] imp_exp [5];
    logic [15:0] ovf_exp;
    imp     = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    imp_exp = '{16'd1, 16'd2, 16'd4, 16'd8, 16'd0};

    rst_n     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    #2;
    do_reset();

    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_coef_ready", coef_ready, 1);

    // impulse response through coefficients 1,2,4,8
    write_coef(2'd0, 16'd1);
    write_coef(2'd1, 16'd2);
    write_coef(2'd2, 16'd4);
    write_coef(2'd3, 16'd8);
    for (int i = 0; i < 5; i++) begin
      accept(0, imp[i]);
      wait_result(0, imp_exp[i]);
    end

    // channel isolation
    accept(1, 16'd100);
    wait_result(1, 16'd100);
    accept(0, 16'd1);
    wait_result(0, 16'd1);
    accept(1, 16'd0);
    wait_result(1, 16'd200);

    // simultaneous held requests from reset, passthrough coefficients
    rst_n = 1'b0;
    req_data  = {16'd30, 16'd20, 16'd10};
    req_valid = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_gated", req_ready, 0);
    rst_n = 1'b1;
    res = 0;
    cyc = 0;
    idle_run = 0;
    while (res < 6 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (out_valid) begin
        check("rr_ch", out_ch, res % 3);
        check("rr_data", out_data, 10 * (res % 3 + 1));
        res++;
      end
      if (!busy) idle_run++;
      else begin
        if (res >= 1 && idle_run > 0) check("idle_gap", idle_run, 1);
        idle_run = 0;
      end
    end
    req_valid = '0;
    check("rr_count", res, 6);

    // coefficient write while busy lands after the in-flight result
    do_reset();
    write_coef(2'd0, 16'd1);
    write_coef(2'd1, 16'd2);
    write_coef(2'd2, 16'd4);
    write_coef(2'd3, 16'd8);
    accept(0, 16'd1);  wait_result(0, 16'd1);
    accept(0, 16'd0);  wait_result(0, 16'd2);
    accept(1, 16'd1);  wait_result(1, 16'd1);
    accept(1, 16'd0);  wait_result(1, 16'd2);
    accept(0, 16'd0);
    coef_we   = 1'b1;
    coef_addr = 2'd2;
    coef_data = 16'd5;
    #1;
    check("coef_busy_ready", coef_ready, 0);
    check("coef_busy", busy, 1);
    wait_result(0, 16'd4);
    @(posedge clk); #1;
    coef_we = 1'b0;
    accept(1, 16'd0);
    wait_result(1, 16'd5);

    // overflow: all coefficients and samples at full scale
    do_reset();
    for (int t = 0; t < 4; t++) write_coef(2'(t), 16'd32767);
    for (int i = 0; i < 4; i++) begin
`ifdef FIR_SAT_EN
      ovf_exp = 16'd32767;
`else
      ovf_exp = 16'(i + 1);
`endif
      accept(2, 16'd32767);
      wait_result(2, ovf_exp);
    end

    // async reset mid-MAC discards the result and restores defaults
    accept(0, 16'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mac_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_coef_ready", coef_ready, 1);
    #1;
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) nvalid++;
    end
    check("arst_no_result", nvalid, 0);
    accept(0, 16'd1);
    wait_result(0, 16'd1);
    accept(0, 16'd0);
    wait_result(0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
